// File: rtl/ram_block_copier_pkg.sv
// Shared RAMControl request-bus definitions: opcodes, default widths, state encodings.
// Reused by RAMControl and every initiator sharing the request bus.
package ram_block_copier_pkg;

  localparam int unsigned RAM_ADDR_W = 23;
  localparam int unsigned RAM_DATA_W = 16;
  localparam int unsigned COPY_LEN_W = 8;

  typedef enum logic {
    RAM_READ  = 1'b0,
    RAM_WRITE = 1'b1
  } ram_op_e;

  typedef enum logic [1:0] {
    PH_NONE,
    PH_ISSUE,
    PH_WAIT_LO,
    PH_WAIT_HI
  } req_phase_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT_LO,
    RD_WAIT_HI,
    WR_ISSUE,
    WR_WAIT_LO,
    WR_WAIT_HI,
    DONE
  } copier_state_e;

  // A handshake phase ends on ready high (issue, wait-high) or ready low (wait-low).
  function automatic logic phase_step(req_phase_e ph, logic ready);
    case (ph)
      PH_ISSUE, PH_WAIT_HI: return ready;
      PH_WAIT_LO:           return !ready;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram_block_copier_if.sv
// RAMControl request bus: the initiator drives owner/instruction/latch/addr/data_wr,
// RAMControl answers with ready and read data.
interface ram_bus_if
  import ram_block_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
);

  logic              ram_owner;
  logic              ram_instruction;
  logic              ram_latch;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_wr;
  logic [DATA_W-1:0] ram_data_rd;
  logic              ram_ready;

  modport master (
    output ram_owner, ram_instruction, ram_latch, ram_addr, ram_data_wr,
    input  ram_data_rd, ram_ready
  );

  modport slave (
    input  ram_owner, ram_instruction, ram_latch, ram_addr, ram_data_wr,
    output ram_data_rd, ram_ready
  );

endinterface

// File: rtl/ram_block_copier_req_port.sv
// Request-port side of one RAMControl initiator: handshake phase completion
// and bus gating, so idle initiators present all-zero and can be OR-combined.
module ram_req_port
  import ram_block_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W
) (
  input  logic              owner,
  input  req_phase_e        phase,
  input  ram_op_e           op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              step,
  output logic [DATA_W-1:0] rd_data,
  ram_bus_if.master         bus
);

  assign step    = owner && phase_step(phase, bus.ram_ready);
  assign rd_data = bus.ram_data_rd;

  // The strobe is combinational on ready so it can only appear in a ready=1 cycle.
  assign bus.ram_owner       = owner;
  assign bus.ram_latch       = owner && (phase == PH_ISSUE) && bus.ram_ready;
  assign bus.ram_instruction = owner && (op == RAM_WRITE);
  assign bus.ram_addr        = owner ? addr    : '0;
  assign bus.ram_data_wr     = owner ? wr_data : '0;

endmodule

// File: rtl/ram_block_copier.sv
// DNA block copy engine: copies length words src->dst in ascending order,
// one read/write pair per word through the shared RAMControl request bus.
module ram_block_copier
  import ram_block_copier_pkg::*;
#(
  parameter int unsigned ADDR_W = RAM_ADDR_W,
  parameter int unsigned DATA_W = RAM_DATA_W,
  parameter int unsigned LEN_W  = COPY_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  ram_bus_if.master         ram
);

  copier_state_e     state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic              owner;
  logic              step;
  req_phase_e        phase;
  ram_op_e           op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign owner = (state_q != IDLE) && (state_q != DONE);

  // Request decode kept apart from next-state so step never feeds back into phase.
  always_comb begin
    phase    = PH_NONE;
    op       = RAM_READ;
    req_addr = src_q;
    case (state_q)
      RD_ISSUE:   phase = PH_ISSUE;
      RD_WAIT_LO: phase = PH_WAIT_LO;
      RD_WAIT_HI: phase = PH_WAIT_HI;
      WR_ISSUE: begin
        phase    = PH_ISSUE;
        op       = RAM_WRITE;
        req_addr = dst_q;
      end
      WR_WAIT_LO: begin
        phase    = PH_WAIT_LO;
        op       = RAM_WRITE;
        req_addr = dst_q;
      end
      WR_WAIT_HI: begin
        phase    = PH_WAIT_HI;
        op       = RAM_WRITE;
        req_addr = dst_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = length;
            state_d = RD_ISSUE;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_ISSUE:   if (step) state_d = RD_WAIT_LO;
      RD_WAIT_LO: if (step) state_d = RD_WAIT_HI;
      RD_WAIT_HI: begin
        if (step) begin
          hold_d  = rd_data;
          state_d = WR_ISSUE;
        end
      end
      WR_ISSUE:   if (step) state_d = WR_WAIT_LO;
      WR_WAIT_LO: if (step) state_d = WR_WAIT_HI;
      WR_WAIT_HI: begin
        if (step) begin
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          state_d = (rem_q == LEN_W'(1)) ? DONE : RD_ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  ram_req_port #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_req_port (
    .owner   (owner),
    .phase   (phase),
    .op      (op),
    .addr    (req_addr),
    .wr_data (hold_q),
    .step    (step),
    .rd_data (rd_data),
    .bus     (ram)
  );

endmodule

// File: tb/tb_ram_block_copier.sv
// Bench for ram_block_copier: a RAMControl-like responder with configurable busy
// time, plus a word-level copy model giving the expected bus operations and memory.
module tb_ram_block_copier;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 8;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [LW-1:0] length = '0;
  logic          busy;
  logic          done;

  ram_bus_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

  ram_block_copier #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .busy     (busy),
    .done     (done),
    .ram      (ram)
  );

  always #5 clk = ~clk;

  // Memory image: seed is the preload, mem holds words written over the bus.
  logic [DW-1:0] seed [logic [AW-1:0]];
  logic [DW-1:0] mem  [logic [AW-1:0]];
  op_t           log_q [$];

  int unsigned cyc = 0, lowlen = 1, hold_until = 0, cnt = 0;
  int unsigned done_cnt = 0, done_cyc = 0, owner_cyc = 0, gate_viol = 0, noready_viol = 0;
  int unsigned n_pass = 0, n_total = 0;

  function automatic logic [DW-1:0] peek(logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    if (seed.exists(a)) return seed[a];
    return '0;
  endfunction

  function automatic int unsigned n_ops(int unsigned from, logic wr);
    int unsigned c = 0;
    for (int unsigned i = from; i < log_q.size(); i++)
      if (log_q[i].wr == wr) c++;
    return c;
  endfunction

  // Responder: samples the bus mid-cycle, answers 1ns after the rising edge.
  initial begin : ram_model
    bit            lat;
    op_t           op;
    logic [DW-1:0] pend;
    pend = '0;
    op   = '0;
    ram.ram_ready   = 1'b1;
    ram.ram_data_rd = '0;
    forever begin
      @(negedge clk);
      lat = 1'b0;
      if (!ram.ram_owner && (ram.ram_latch || ram.ram_instruction ||
                             ram.ram_addr != '0 || ram.ram_data_wr != '0)) gate_viol++;
      if (ram.ram_latch && !ram.ram_ready) noready_viol++;
      if (ram.ram_owner) owner_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst_n) begin
        lat     = ram.ram_latch;
        op.wr   = ram.ram_instruction;
        op.addr = ram.ram_addr;
        op.data = ram.ram_instruction ? ram.ram_data_wr : '0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        ram.ram_ready = 1'b1;
        cnt = 0;
      end else if (lat) begin
        log_q.push_back(op);
        if (op.wr) mem[op.addr] = op.data;
        else       pend = peek(op.addr);
        ram.ram_ready   = 1'b0;
        ram.ram_data_rd = DW'($urandom);
        cnt = lowlen;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ram.ram_ready   = 1'b1;
          ram.ram_data_rd = pend;
        end
      end else begin
        ram.ram_ready = (cyc >= hold_until);
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, " busy"},  64'(busy), 64'(0));
    check({tag, " done"},  64'(done), 64'(0));
    check({tag, " owner"}, 64'(ram.ram_owner), 64'(0));
    check({tag, " latch"}, 64'(ram.ram_latch), 64'(0));
    check({tag, " instr"}, 64'(ram.ram_instruction), 64'(0));
    check({tag, " addr"},  64'(ram.ram_addr), 64'(0));
    check({tag, " wdata"}, 64'(ram.ram_data_wr), 64'(0));
  endtask

  task automatic start_copy(logic [AW-1:0] s, logic [AW-1:0] d, logic [LW-1:0] n,
                            output int unsigned sc);
    src_addr = s;
    dst_addr = d;
    length   = n;
    start    = 1'b1;
    sc       = cyc;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(int unsigned d0, int unsigned limit);
    for (int unsigned i = 0; i < limit && done_cnt == d0; i++) tick();
  endtask

  task automatic copy_and_check(string tag, logic [AW-1:0] s, logic [AW-1:0] d,
                                int unsigned n, int unsigned lw, bit chk_lat,
                                int unsigned poke_at);
    op_t exp_q [$];
    int unsigned lb, d0, sc;
    for (int unsigned i = 0; i < n; i++) begin
      op_t r, w;
      r.wr = 1'b0; r.addr = s + AW'(i); r.data = '0;
      w.wr = 1'b1; w.addr = d + AW'(i); w.data = peek(s + AW'(i));
      exp_q.push_back(r);
      exp_q.push_back(w);
    end
    lowlen = lw;
    lb = log_q.size();
    d0 = done_cnt;
    start_copy(s, d, LW'(n), sc);
    if (poke_at > 0) begin
      repeat (poke_at) tick();
      src_addr = 23'h000900;
      dst_addr = 23'h000A00;
      length   = 8'd5;
      start    = 1'b1;
      tick();
      start    = 1'b0;
    end
    wait_done(d0, 4000);
    check({tag, " done pulse"}, 64'(done), 64'(1));
    check({tag, " busy in DONE"}, 64'(busy), 64'(1));
    if (chk_lat) check({tag, " latency"}, 64'(done_cyc - sc), 64'(n * (2 * lw + 4) + 1));
    tick();
    check({tag, " done count"}, 64'(done_cnt - d0), 64'(1));
    check({tag, " busy after"}, 64'(busy), 64'(0));
    check({tag, " op count"}, 64'(log_q.size() - lb), 64'(2 * n));
    for (int unsigned i = 0; i < exp_q.size(); i++)
      if (lb + i < log_q.size())
        check($sformatf("%s op%0d", tag, i), 64'(log_q[lb + i]), 64'(exp_q[i]));
    for (int unsigned i = 0; i < n; i++)
      check($sformatf("%s dst[%0d]", tag, i), 64'(peek(d + AW'(i))), 64'(exp_q[2 * i + 1].data));
  endtask

  initial begin : stimulus
    int unsigned lb, d0, o0, sc;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Directed 4-word block with a 2-cycle busy RAM.
    seed[23'h000100] = 16'h00A1;
    seed[23'h000101] = 16'h00B2;
    seed[23'h000102] = 16'h00C3;
    seed[23'h000103] = 16'h00D4;
    lb = log_q.size();
    copy_and_check("blk4", 23'h000100, 23'h000200, 4, 2, 1'b1, 0);
    check("blk4 reads",  64'(n_ops(lb, 1'b0)), 64'(4));
    check("blk4 writes", 64'(n_ops(lb, 1'b1)), 64'(4));
    check("blk4 mem200", 64'(peek(23'h000200)), 64'(16'h00A1));
    check("blk4 mem203", 64'(peek(23'h000203)), 64'(16'h00D4));

    // Zero length: start cycle then DONE, no bus ownership.
    o0 = owner_cyc;
    lb = log_q.size();
    d0 = done_cnt;
    start_copy(23'h000111, 23'h000222, 8'd0, sc);
    wait_done(d0, 50);
    check("len0 done", 64'(done), 64'(1));
    check("len0 latency", 64'(done_cyc - sc), 64'(1));
    tick();
    check("len0 done count", 64'(done_cnt - d0), 64'(1));
    check("len0 owner", 64'(owner_cyc - o0), 64'(0));
    check("len0 ops", 64'(log_q.size() - lb), 64'(0));

    // Ready held low before the first issue.
    seed[23'h000800] = 16'h1234;
    seed[23'h000801] = 16'h5678;
    hold_until = cyc + 12;
    tick();
    copy_and_check("hold", 23'h000800, 23'h000880, 2, 1, 1'b0, 0);

    // Source pointer wraps past the top of the address space.
    seed[23'h7FFFFE] = 16'hBEEF;
    seed[23'h7FFFFF] = 16'hCAFE;
    seed[23'h000000] = 16'hF00D;
    copy_and_check("wrap", 23'h7FFFFE, 23'h000010, 3, 1, 1'b1, 0);

    // A second start while busy is dropped.
    for (int unsigned i = 0; i < 3; i++) seed[23'h000700 + AW'(i)] = DW'($urandom);
    seed[23'h000900] = 16'h9999;
    d0 = done_cnt;
    copy_and_check("restart", 23'h000700, 23'h000780, 3, 1, 1'b1, 4);
    repeat (30) tick();
    check("restart no 2nd done", 64'(done_cnt - d0), 64'(1));
    check("restart busy", 64'(busy), 64'(0));
    check("restart no A00 write", 64'(mem.exists(23'h000A00)), 64'(0));

    // Randomized blocks with random RAM busy time.
    for (int unsigned t = 0; t < 6; t++) begin
      logic [AW-1:0] s, d;
      int unsigned n, lw;
      s  = AW'(23'h010000 * (t + 1)) + AW'($urandom_range(0, 255));
      d  = AW'(23'h010000 * (t + 1)) + AW'(23'h008000) + AW'($urandom_range(0, 255));
      n  = $urandom_range(1, 8);
      lw = $urandom_range(1, 3);
      for (int unsigned i = 0; i < n; i++) seed[s + AW'(i)] = DW'($urandom);
      copy_and_check($sformatf("rnd%0d", t), s, d, n, lw, 1'b1, 0);
    end

    // Asynchronous reset during the second word's write wait.
    for (int unsigned i = 0; i < 4; i++) seed[23'h000300 + AW'(i)] = DW'($urandom);
    lowlen = 4;
    lb = log_q.size();
    d0 = done_cnt;
    start_copy(23'h000300, 23'h000400, 8'd4, sc);
    for (int unsigned i = 0; i < 500 && n_ops(lb, 1'b1) < 2; i++) tick();
    tick();
    check("rst pre owner", 64'(ram.ram_owner), 64'(1));
    check("rst pre instr", 64'(ram.ram_instruction), 64'(1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("midrst no done", 64'(done_cnt - d0), 64'(0));
    check("midrst dst0", 64'(peek(23'h000400)), 64'(seed[23'h000300]));
    check("midrst dst1", 64'(peek(23'h000401)), 64'(seed[23'h000301]));
    check("midrst dst2 untouched", 64'(mem.exists(23'h000402)), 64'(0));
    seed[23'h000500] = 16'h4242;
    copy_and_check("postrst", 23'h000500, 23'h000600, 1, 1, 1'b1, 0);

    check("bus gating", 64'(gate_viol), 64'(0));
    check("latch only when ready", 64'(noready_viol), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
